// File: rtl/serial_pkg.sv
// Shared definitions for the 40-bit serial frame link (sender and receiver).
package serial_pkg;

  localparam int FRAME_BITS = 40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP,
    FLUSH
  } rx_state_t;

  function automatic int cnt_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Output side of the serial receiver: one-entry frame register plus status pulses.
interface serial_receiver_if
  import serial_pkg::*;
#(
  parameter int W = serial_pkg::FRAME_BITS
) ();

  // out_valid rises when a frame is loaded and holds, with out_data stable,
  // until a rising edge sees out_valid && out_ready; that edge is the transfer.
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic         overrun;
  rx_state_t    state;

  modport master (
    output out_data, out_valid, frame_err, overrun, state,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, frame_err, overrun, state,
    output out_ready
  );

endinterface

// File: rtl/serial_receiver_fsm.sv
// Frame FSM: start detect, MSB-first shift, stop check, and the one-entry output buffer.
module serial_receiver_fsm
  import serial_pkg::*;
#(
  parameter int FRAME_BITS = serial_pkg::FRAME_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  serial_receiver_if.master bus
);

  localparam int CNT_W = cnt_width(FRAME_BITS);

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d, data_q;
  logic                  valid_q, err_q, ovr_q;
  logic                  deliver, bad_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    case (state_q)
      IDLE: begin
        if (sin) begin
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], sin};
        // Exit on the last sample instead of incrementing, so count never wraps.
        if (count_q == CNT_W'(FRAME_BITS - 1)) state_d = STOP;
        else                                   count_d = count_q + 1'b1;
      end
      STOP: begin
        if (sin) begin
          bad_stop = 1'b1;
          state_d  = FLUSH;
        end else begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // Wait for the line to drop so a stuck-high line cannot look like a start bit.
        if (!sin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      err_q <= bad_stop;
      ovr_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || bus.out_ready) begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.overrun   = ovr_q;
  assign bus.state     = state_q;

endmodule

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer, asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// 40-bit serial frame deserializer. Define SERIAL_RX_SYNC_EN to put a 2-flop
// synchronizer on sin (adds 2 clocks to every latency).
module serial_receiver
  import serial_pkg::*;
#(
  parameter int FRAME_BITS = serial_pkg::FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin,
  output logic [FRAME_BITS-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output rx_state_t             state
);

  logic sin_fsm;

`ifdef SERIAL_RX_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sin),
    .q   (sin_fsm)
  );
`else
  assign sin_fsm = sin;
`endif

  serial_receiver_if #(.W(FRAME_BITS)) bus ();

  serial_receiver_fsm #(.FRAME_BITS(FRAME_BITS)) u_fsm (
    .clk (clk),
    .rst (rst),
    .sin (sin_fsm),
    .bus (bus)
  );

  assign bus.out_ready = out_ready;
  assign out_data      = bus.out_data;
  assign out_valid     = bus.out_valid;
  assign frame_err     = bus.frame_err;
  assign overrun       = bus.overrun;
  assign state         = bus.state;

endmodule
